// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive end: oversampled pins, MSB-first deserialiser,
// and a first-fall-through FIFO with a valid/ready read port.
module spi_slave_rx #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sclk,
  input  logic              spi_sdo,
  input  logic              spi_cs,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic {IDLE, SHIFT} state_e;

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] sdo_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic                   sclk_dly_q;
  logic                   sclk_s;
  logic                   sdo_s;
  logic                   cs_s;
  logic                   rise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_q     <= '0;
      sdo_q      <= '0;
      cs_q       <= '1;
      sclk_dly_q <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      sdo_q      <= {sdo_q[SYNC_STAGES-2:0], spi_sdo};
      cs_q       <= {cs_q[SYNC_STAGES-2:0], spi_cs};
      sclk_dly_q <= sclk_s;
    end
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign sdo_s  = sdo_q[SYNC_STAGES-1];
  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_dly_q;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic              push_q;
  logic              frame_err_q;

  // push_q marks the cycle after the last bit; shreg_q then holds the word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!cs_s) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            state_q     <= IDLE;
            frame_err_q <= (cnt_q != '0);
            cnt_q       <= '0;
          end else if (rise) begin
            shreg_q <= {shreg_q[DATA_W-2:0], sdo_s};
            if (cnt_q == CNT_LAST) begin
              cnt_q  <= '0;
              push_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q == SHIFT);
  assign frame_err_o = frame_err_q;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wptr_q;
  logic [AW:0]       rptr_q;
  logic [DATA_W-1:0] last_q;
  logic              overflow_q;
  logic              empty;
  logic              full;
  logic              pop;
  logic              wr;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && rx_ready_i;
  assign wr    = push_q && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= shreg_q;
  end

  // last_q keeps the most recently popped word visible while empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_q && full && !pop;
      if (wr) wptr_q <= wptr_q + PTR_ONE;
      if (pop) begin
        rptr_q <= rptr_q + PTR_ONE;
        last_q <= mem_q[rptr_q[AW-1:0]];
      end
    end
  end

  assign rx_valid_o = !empty;
  assign rx_data_o  = empty ? last_q : mem_q[rptr_q[AW-1:0]];
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: framing, back-to-back words,
// frame errors, overflow, pop-on-push and mid-word reset.
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        sdo = 1'b0;
  logic        cs = 1'b1;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        busy;
  logic        frame_err;
  logic        overflow;

  int n_chk = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_gap = 0;
  bit in_frame = 1'b0;
  logic [31:0] popped [$];

  always #5 clk = ~clk;

  spi_slave_rx dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .spi_sclk    (sclk),
    .spi_sdo     (sdo),
    .spi_cs      (cs),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .busy_o      (busy),
    .frame_err_o (frame_err),
    .overflow_o  (overflow)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) popped.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overflow) ov_cnt++;
      if (in_frame && !busy) busy_gap++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    cs = 1'b0;
    clks(4);
  endtask

  task automatic cs_high();
    clks(4);
    cs = 1'b1;
    clks(6);
  endtask

  // sclk = clk/8; optional pop is placed in the push cycle of the last bit
  task automatic send(input logic [31:0] w, input int n, input bit pop_end);
    for (int i = 0; i < n; i++) begin
      sdo = w[31-i];
      clks(4);
      sclk = 1'b1;
      if (pop_end && i == n - 1) begin
        clks(3);
        rx_ready = 1'b1;
        clks(1);
        rx_ready = 1'b0;
      end else begin
        clks(4);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] w);
    cs_low();
    send(w, 32, 1'b0);
    cs_high();
  endtask

  int fe0, ov0, np0;

  initial begin
    clks(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    clks(3);

    frame(32'hA5C3_0F96);
    check("t1_valid", rx_valid, 1);
    check("t1_data", rx_data, 32'hA5C30F96);
    rx_ready = 1'b1;
    clks(3);
    check("t1_count", popped.size(), 1);
    check("t1_empty", rx_valid, 0);
    check("t1_ferr", fe_cnt, 0);
    check("t1_ovf", ov_cnt, 0);

    np0 = popped.size();
    cs_low();
    in_frame = 1'b1;
    send(32'h0000_0001, 32, 1'b0);
    send(32'h8000_0000, 32, 1'b0);
    send(32'hFFFF_FFFF, 32, 1'b0);
    clks(4);
    in_frame = 1'b0;
    cs_high();
    check("t2_count", popped.size() - np0, 3);
    check("t2_w0", popped[np0], 32'h00000001);
    check("t2_w1", popped[np0+1], 32'h80000000);
    check("t2_w2", popped[np0+2], 32'hFFFFFFFF);
    check("t2_busy", busy_gap, 0);
    check("t2_ferr", fe_cnt, 0);

    fe0 = fe_cnt;
    cs_low();
    send(32'hFFF8_0000, 13, 1'b0);
    cs_high();
    check("t3_ferr", fe_cnt - fe0, 1);
    check("t3_empty", rx_valid, 0);
    np0 = popped.size();
    frame(32'h1234_5678);
    check("t3_count", popped.size() - np0, 1);
    check("t3_word", popped[np0], 32'h12345678);

    rx_ready = 1'b0;
    ov0 = ov_cnt;
    cs_low();
    for (int k = 1; k <= 5; k++) send(32'(k), 32, 1'b0);
    cs_high();
    check("t4_ovf", ov_cnt - ov0, 1);
    check("t4_head", rx_data, 1);
    np0 = popped.size();
    rx_ready = 1'b1;
    clks(6);
    check("t4_count", popped.size() - np0, 4);
    for (int k = 0; k < 4; k++) check("t4_word", popped[np0+k], 32'(k + 1));
    check("t4_empty", rx_valid, 0);

    rx_ready = 1'b0;
    ov0 = ov_cnt;
    cs_low();
    for (int k = 10; k <= 13; k++) send(32'(k), 32, 1'b0);
    np0 = popped.size();
    send(32'd14, 32, 1'b1);
    cs_high();
    check("t5_ovf", ov_cnt - ov0, 0);
    check("t5_pop1", popped.size() - np0, 1);
    rx_ready = 1'b1;
    clks(6);
    check("t5_count", popped.size() - np0, 5);
    for (int k = 0; k < 5; k++) check("t5_word", popped[np0+k], 32'(k + 10));

    rx_ready = 1'b0;
    cs_low();
    send(32'hAAAA_0001, 32, 1'b0);
    send(32'h5555_0002, 32, 1'b0);
    send(32'hFFFF_F000, 20, 1'b0);
    check("t6_pre", rx_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_valid", rx_valid, 0);
    check("t6_data", rx_data, 0);
    check("t6_busy", busy, 0);
    check("t6_ferr", frame_err, 0);
    check("t6_ovf", overflow, 0);
    cs = 1'b1;
    sclk = 1'b0;
    clks(3);
    rst = 1'b0;
    fe0 = fe_cnt;
    clks(3);
    frame(32'hDEAD_BEEF);
    check("t6_new", rx_data, 32'hDEADBEEF);
    check("t6_nvalid", rx_valid, 1);
    check("t6_nferr", fe_cnt - fe0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
